// File: rtl/my_pkg.sv
// Shared types for the instruction-memory side of the fetch path.
package my_pkg;

  // Responder FSM states; suffixed to stay distinct from the FSM_MEM_states_reg literals.
  typedef enum logic [1:0] {
    IDLE_R,
    READ_R,
    WRITE_R,
    RESP_R
  } FSM_IMEM_RESP_states;

  // Width of the latency counter; both latencies must fit in it.
  localparam int IMEM_CNT_W = 4;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: DEPTH x DATA_W registers, synchronous write, combinational read, no reset.
module imem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Single write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/imem_responder.sv
// Memory-side responder for instruction fetch: fixed-latency reads, abortable by
// dropping mem_csb, and non-abortable single-word writes.
module imem_responder
  import my_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mem_csb,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wack,
  output logic              busy
);

  localparam logic [IMEM_CNT_W-1:0] RD_LAST = IMEM_CNT_W'(RD_LATENCY - 1);
  localparam logic [IMEM_CNT_W-1:0] WR_LAST = IMEM_CNT_W'(WR_LATENCY - 1);

  FSM_IMEM_RESP_states state_q, state_d;
  logic [IMEM_CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  op_rd_q, op_rd_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic                  arrWe;
  logic [DATA_W-1:0]     arrRdata;

  imem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .we_i    (arrWe),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (arrRdata)
  );

  // State, counter, request latches and the read-data register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE_R;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_rd_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_rd_q <= op_rd_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic; the array write strobe is decoded from the registered state,
  // so an asynchronous reset in WRITE suppresses the commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_rd_d = op_rd_q;
    rdata_d = rdata_q;
    arrWe   = 1'b0;
    case (state_q)
      IDLE_R: begin
        if (mem_csb) begin
          addr_d = mem_addr;
          cnt_d  = '0;
          if (mem_we) begin
            wdata_d = mem_wdata;
            op_rd_d = 1'b0;
            state_d = WRITE_R;
          end else begin
            op_rd_d = 1'b1;
            state_d = READ_R;
          end
        end
      end
      READ_R: begin
        cnt_d = cnt_q + 1'b1;
        if (!mem_csb) begin
          cnt_d   = '0;
          state_d = IDLE_R;
        end else if (cnt_q == RD_LAST) begin
          rdata_d = arrRdata;
          state_d = RESP_R;
        end
      end
      WRITE_R: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == WR_LAST) begin
          arrWe   = 1'b1;
          state_d = RESP_R;
        end
      end
      RESP_R: begin
        state_d = IDLE_R;
      end
      default: begin
        state_d = IDLE_R;
      end
    endcase
  end

  assign rdata  = rdata_q;
  assign rvalid = (state_q == RESP_R) && op_rd_q;
  assign wack   = (state_q == RESP_R) && !op_rd_q;
  assign busy   = (state_q != IDLE_R);

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: default-latency instance plus RD_LATENCY=1 and 5 instances.
`timescale 1ns/1ps
module tb_imem_responder;

  localparam int RDL = 2;
  localparam int WRL = 1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        csb, we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid, wack, busy;

  logic        csbL1, csbL5, weX;
  logic [7:0]  addrX;
  logic [31:0] wdataX;
  logic [31:0] rdataL1, rdataL5;
  logic        rvalidL1, wackL1, busyL1;
  logic        rvalidL5, wackL5, busyL5;

  int errors = 0;
  int checks = 0;

  logic [31:0] modelMem [256];
  logic [31:0] expQ [$];

  always #5 clk = ~clk;

  imem_responder #(.ADDR_W(8), .DATA_W(32), .RD_LATENCY(RDL), .WR_LATENCY(WRL)) dut (
    .clk(clk), .rstn(rstn), .mem_csb(csb), .mem_we(we), .mem_addr(addr), .mem_wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .wack(wack), .busy(busy)
  );

  imem_responder #(.ADDR_W(8), .DATA_W(32), .RD_LATENCY(1), .WR_LATENCY(1)) dutL1 (
    .clk(clk), .rstn(rstn), .mem_csb(csbL1), .mem_we(weX), .mem_addr(addrX), .mem_wdata(wdataX),
    .rdata(rdataL1), .rvalid(rvalidL1), .wack(wackL1), .busy(busyL1)
  );

  imem_responder #(.ADDR_W(8), .DATA_W(32), .RD_LATENCY(5), .WR_LATENCY(1)) dutL5 (
    .clk(clk), .rstn(rstn), .mem_csb(csbL5), .mem_we(weX), .mem_addr(addrX), .mem_wdata(wdataX),
    .rdata(rdataL5), .rvalid(rvalidL5), .wack(wackL5), .busy(busyL5)
  );

  // Raise a write request on the default instance and count cycles until wack.
  task automatic applyWrite(input logic [7:0] a, input logic [31:0] d, output int lat);
    @(negedge clk);
    csb = 1'b1; we = 1'b1; addr = a; wdata = d;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (wack) break;
    end
    csb = 1'b0; we = 1'b0;
    modelMem[a] = d;
  endtask

  // Raise a read request on the default instance and count cycles until rvalid.
  task automatic applyRead(input logic [7:0] a, output int lat, output logic [31:0] got);
    @(negedge clk);
    csb = 1'b1; we = 1'b0; addr = a;
    lat = 0;
    got = 'x;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rvalid) begin
        got = rdata;
        break;
      end
    end
    csb = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; csb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    csbL1 = 1'b0; csbL5 = 1'b0; weX = 1'b0; addrX = '0; wdataX = '0;
    repeat (3) @(negedge clk);
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected %h", rdata, 32'h0); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected 0", rvalid); end
    checks++; if (wack !== 1'b0) begin errors++; $display("[TB] FAIL reset_wack: got %b expected 0", wack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_write_read();
    int lat;
    logic [31:0] got, exp;
    applyWrite(8'h01, 32'hDEADBEEF, lat);
    checks++; if (lat != WRL + 1) begin errors++; $display("[TB] FAIL wr_latency: got %0d expected %0d", lat, WRL + 1); end
    expQ.push_back(modelMem[8'h01]);
    applyRead(8'h01, lat, got);
    checks++; if (lat != RDL + 1) begin errors++; $display("[TB] FAIL rd_latency: got %0d expected %0d", lat, RDL + 1); end
    exp = expQ.pop_front();
    checks++; if (got !== exp) begin errors++; $display("[TB] FAIL rd_data: got %h expected %h", got, exp); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rd_after_busy: got busy=%b rvalid=%b expected 0 0", busy, rvalid); end
  endtask

  task automatic test_startup();
    int lat;
    logic [31:0] got, exp;
    applyWrite(8'h01, 32'hFFFFFFFF, lat);
    expQ.push_back(modelMem[8'h01]);
    applyRead(8'h01, lat, got);
    exp = expQ.pop_front();
    checks++; if (got !== exp) begin errors++; $display("[TB] FAIL startup_data: got %h expected %h", got, exp); end
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    csb = 1'b1; we = 1'b0; addr = 8'h10;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy_read: got %b expected 1", busy); end
    csb = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy_low: got %b expected 0", busy); end
    checks++; if (rdata !== modelMem[8'h01]) begin errors++; $display("[TB] FAIL abort_rdata_hold: got %h expected %h", rdata, modelMem[8'h01]); end
    seen = 0;
    repeat (6) begin
      if (rvalid) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL abort_no_rvalid: got %0d pulses expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat, cyc, n, last;
    logic [7:0] addrs [3];
    logic [31:0] exp;
    addrs[0] = 8'h20; addrs[1] = 8'h21; addrs[2] = 8'h22;
    applyWrite(8'h20, 32'h11112222, lat);
    applyWrite(8'h21, 32'h33334444, lat);
    applyWrite(8'h22, 32'h55556666, lat);
    for (int i = 0; i < 3; i++) expQ.push_back(modelMem[addrs[i]]);
    @(negedge clk);
    csb = 1'b1; we = 1'b0; addr = addrs[0];
    cyc = 0; n = 0; last = 0;
    while (n < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (rvalid) begin
        exp = expQ.pop_front();
        checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", n, rdata, exp); end
        if (n > 0) begin
          checks++; if (cyc - last != RDL + 2) begin errors++; $display("[TB] FAIL b2b_period%0d: got %0d expected %0d", n, cyc - last, RDL + 2); end
        end
        last = cyc;
        n++;
        if (n < 3) addr = addrs[n];
        else csb = 1'b0;
      end
    end
    csb = 1'b0;
    checks++; if (n != 3) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 3", n); end
  endtask

  task automatic test_wrap();
    int lat;
    logic [31:0] got, exp;
    applyWrite(8'h00, 32'hA5A5A5A5, lat);
    applyWrite(8'hFF, 32'h12345678, lat);
    expQ.push_back(modelMem[8'hFF]);
    applyRead(8'hFF, lat, got);
    exp = expQ.pop_front();
    checks++; if (got !== exp) begin errors++; $display("[TB] FAIL wrap_ff: got %h expected %h", got, exp); end
    expQ.push_back(modelMem[8'h00]);
    applyRead(8'h00, lat, got);
    exp = expQ.pop_front();
    checks++; if (got !== exp) begin errors++; $display("[TB] FAIL wrap_00: got %h expected %h", got, exp); end
  endtask

  task automatic test_reset_mid_write();
    int lat, seen;
    logic [31:0] got, exp;
    @(negedge clk);
    csb = 1'b1; we = 1'b1; addr = 8'h20; wdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rstw_busy_write: got %b expected 1", busy); end
    rstn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstw_busy_async: got %b expected 0", busy); end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (wack) seen++;
    end
    csb = 1'b0; we = 1'b0;
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (wack) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL rstw_no_wack: got %0d pulses expected 0", seen); end
    expQ.push_back(modelMem[8'h20]);
    applyRead(8'h20, lat, got);
    exp = expQ.pop_front();
    checks++; if (got !== exp) begin errors++; $display("[TB] FAIL rstw_old_data: got %h expected %h", got, exp); end
  endtask

  task automatic test_latency();
    int cyc, latL1, latL5;
    logic [31:0] exp;
    @(negedge clk);
    csbL1 = 1'b1; csbL5 = 1'b1; weX = 1'b1; addrX = 8'h33; wdataX = 32'h0BADCAFE;
    cyc = 0;
    while ((csbL1 || csbL5) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (wackL1) csbL1 = 1'b0;
      if (wackL5) csbL5 = 1'b0;
    end
    csbL1 = 1'b0; csbL5 = 1'b0; weX = 1'b0;
    expQ.push_back(32'h0BADCAFE);
    expQ.push_back(32'h0BADCAFE);
    @(negedge clk);
    csbL1 = 1'b1; csbL5 = 1'b1;
    cyc = 0; latL1 = -1; latL5 = -1;
    while ((csbL1 || csbL5) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rvalidL1 && csbL1) begin
        latL1 = cyc; csbL1 = 1'b0;
        exp = expQ.pop_front();
        checks++; if (rdataL1 !== exp) begin errors++; $display("[TB] FAIL lat1_data: got %h expected %h", rdataL1, exp); end
      end
      if (rvalidL5 && csbL5) begin
        latL5 = cyc; csbL5 = 1'b0;
        exp = expQ.pop_front();
        checks++; if (rdataL5 !== exp) begin errors++; $display("[TB] FAIL lat5_data: got %h expected %h", rdataL5, exp); end
      end
    end
    csbL1 = 1'b0; csbL5 = 1'b0;
    checks++; if (latL1 != 2) begin errors++; $display("[TB] FAIL lat1_offset: got %0d expected 2", latL1); end
    checks++; if (latL5 != 6) begin errors++; $display("[TB] FAIL lat5_offset: got %0d expected 6", latL5); end
  endtask

  // Overall time limit so a stuck DUT cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    test_reset();
    test_write_read();
    test_startup();
    test_abort();
    test_back_to_back();
    test_wrap();
    test_reset_mid_write();
    test_latency();
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_left: got %0d expected 0", expQ.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
